alu_ctrl_md: RTL
================

# alu_ctrl_md

Parametrised successor to the base ALU control decoder for the RV32IM core. It decodes ALUOp, funct3 and funct7 into the existing 4-bit ALU control code. It also adds the M extension: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU run on an iterative multi-cycle multiply/divide sequencer. The block sits in EX beside the ALU and stalls the pipeline while an M operation is in flight.

## Interface
- XLEN, 32, operand/result width; must be ≥ 8.
- EN_M, 1, 1 enables M-extension decode and sequencer; 0 decodes funct7=0000001 as the base op and never stalls.

- clk  in  1  clock.
- rst  in  1  reset; synchronous and active-high.
- valid  in  1  instruction present in EX this cycle.
- flush  in  1  abort any in-flight M op.
- ALUOp  in  2  00 add, 01 branch, 10 R-type, 11 I-type.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7.
- rs1_val  in  XLEN  operand A.
- rs2_val  in  XLEN  operand B.
- ALUCtrlOut  out  4  ALU control code.
- md_sel  out  1  writeback takes md_result instead of the ALU result.
- stall  out  1  hold EX and everything upstream.
- md_result  out  XLEN  registered M-op result.
- md_done  out  1  one-cycle pulse; md_result valid.

## Operation
- ALU codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU.
- ALUOp=00 → ADD.
- ALUOp=01 (branch), by funct3:
  - 000/001 → SUB.
  - 100/101 → SLT.
  - 110/111 → SLTU.
  - 010/011 → ADD.
- ALUOp=10/11, by funct3:
  - 111 AND; 110 OR; 100 XOR; 001 SLL; 010 SLT; 011 SLTU.
  - 101 → SRA if funct7=0100000, else SRL.
  - 000 → SUB only for ALUOp=10 with funct7=0100000, else ADD.
- Default for any other combination: ADD.
- M op when EN_M=1, ALUOp=10 and funct7=0000001.
  - md_sel=1 combinationally.
  - ALUCtrlOut=0000.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE → MUL or DIV on valid and an M op:
  - latch magnitudes of the operands: signed per funct3 for MULH/MULHSU(rs1 only)/DIV/REM;
  - latch the result sign;
  - clear the iteration counter.
- MUL: radix-2 shift-add on the unsigned magnitudes into a 2·XLEN accumulator; XLEN iterations, then DONE.
- DIV: restoring unsigned division; XLEN iterations, then DONE.
- MUL result selection: funct3=000 takes the low half; all others take the high half after a 2·XLEN two's-complement negate if the sign is set.
- DIV result: quotient is negated if sign(rs1)^sign(rs2), signed ops only; remainder takes the sign of rs1.
- Fast path, IDLE → DONE directly, with no iteration state:
  - divisor = 0: quotient = all ones; remainder = rs1.
  - signed overflow (rs1 = most negative, rs2 = −1): quotient = rs1; remainder = 0.
- DONE:
  - md_result is registered on entry to DONE; md_done=1 in DONE.
  - always → IDLE.
  - md_result holds until the next DONE.
- flush in MUL or DIV: → IDLE next cycle; no md_done; md_result unchanged. flush has priority over accept in IDLE.
- Reset, including mid-operation, forces:
  - IDLE;
  - stall=0;
  - md_done=0;
  - md_result=0;
  - counter=0.

## Timing
- Decode path (ALUCtrlOut, md_sel) is purely combinational; zero latency.
- stall = (IDLE & valid & M op & ~flush) | MUL | DIV. It is combinational and deasserts in DONE.
- Accept at cycle T, then:
  - iterative op: stall high T..T+XLEN; DONE at T+XLEN+1.
  - total EX occupancy is XLEN+2 cycles (34 for XLEN=32).
- Fast path: stall high at T only; DONE at T+1.
- Pipeline advances at the end of the DONE cycle. The upstream stage must hold valid, funct fields and operands stable while stall=1.
- An M op presented in the cycle after DONE is a new op and is accepted. There is no bubble requirement.
- During rst, all outputs are at reset values regardless of inputs, except the combinational decode.

## Test plan
- Base decode sweep:
  - ALUOp=10, f3=000, f7=0100000 → 0001.
  - ALUOp=11, f3=000, f7=0100000 → 0000.
  - ALUOp=11, f3=101, f7=0100000 → 0111.
  - ALUOp=01, f3=110 → 1001.
  - stall stays 0 throughout.
- MUL rs1=7, rs2=0xFFFFFFFD → stall 33 cycles, md_done at T+33, md_result=0xFFFFFFEB. Then MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV rs1=−7, rs2=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. MULHSU −1×2 → 0xFFFFFFFF.
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF, done at T+1.
  - REMU 5/0 → 5.
  - DIV 0x80000000/−1 → 0x80000000.
  - REM same operands → 0.
- Abort cases:
  - rst asserted at T+10 of a MUL → next cycle IDLE, stall=0, md_done never pulses, md_result=0.
  - flush at T+5 of a DIV → IDLE, prior md_result retained.
- EN_M=0: ALUOp=10, f7=0000001, f3=000 → ALUCtrlOut=0000, md_sel=0, stall=0.

Source files
------------

// File: rtl/alu_ctrl_md.sv
// ALU control decoder for RV32IM with an iterative multiply/divide sequencer.
// Base instructions decode combinationally to a 4-bit ALU control code.
// M-extension ops run on a shift-add multiplier or a restoring divider.
// Both share one 2*XLEN accumulator, and EX stalls while an M op is in flight.
module alu_ctrl_md #(
  parameter int XLEN = 32,
  parameter int EN_M = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic            flush,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic [3:0]      ALUCtrlOut,
  output logic            md_sel,
  output logic            stall,
  output logic [XLEN-1:0] md_result,
  output logic            md_done
);

  localparam int            CW   = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_nxt;

  // Two's-complement negate when requested.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // High half of a conditionally negated 2*XLEN value {hi, lo}.
  // The +1 of the negate only carries into hi when lo is all zeros.
  function automatic logic [XLEN-1:0] neg_hi(input logic [XLEN-1:0] hi,
                                             input logic [XLEN-1:0] lo,
                                             input logic neg);
    logic [XLEN-1:0] carry;
    carry = {{(XLEN-1){1'b0}}, (lo == '0)};
    return neg ? (~hi + carry) : hi;
  endfunction

  logic                is_m;
  logic                accept;
  logic                op_div, sgn_a_op, sgn_b_op, neg_a, neg_b;
  logic                div_zero, div_ovf, fast;
  logic [XLEN-1:0]     mag_a, mag_b, fast_res;

  logic [CW-1:0]       cnt;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     op_reg;
  logic                neg_p, neg_r;
  logic [2:0]          f3_q;

  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_nxt;
  logic [XLEN:0]       div_rs, div_diff;
  logic [2*XLEN-1:0]   div_nxt, acc_nxt;
  logic [XLEN-1:0]     quo, rem, final_res;

  assign is_m   = (EN_M != 0) && (ALUOp == 2'b10) && (funct7 == 7'b0000001);
  assign md_sel = is_m;
  assign accept = (state == IDLE) && valid && is_m && !flush;

  // Base ALU control decode; M ops force ADD.
  always_comb begin
    ALUCtrlOut = ALU_ADD;
    case (ALUOp)
      2'b00: ALUCtrlOut = ALU_ADD;
      2'b01: begin
        case (funct3)
          3'b000, 3'b001: ALUCtrlOut = ALU_SUB;
          3'b100, 3'b101: ALUCtrlOut = ALU_SLT;
          3'b110, 3'b111: ALUCtrlOut = ALU_SLTU;
          default:        ALUCtrlOut = ALU_ADD;
        endcase
      end
      default: begin
        case (funct3)
          3'b111: ALUCtrlOut = ALU_AND;
          3'b110: ALUCtrlOut = ALU_OR;
          3'b100: ALUCtrlOut = ALU_XOR;
          3'b001: ALUCtrlOut = ALU_SLL;
          3'b010: ALUCtrlOut = ALU_SLT;
          3'b011: ALUCtrlOut = ALU_SLTU;
          3'b101: ALUCtrlOut = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
          default: ALUCtrlOut = ((ALUOp == 2'b10) && (funct7 == 7'b0100000)) ? ALU_SUB : ALU_ADD;
        endcase
      end
    endcase
    if (is_m) ALUCtrlOut = ALU_ADD;
  end

  // Operand conditioning at accept: magnitudes, signs and divide special cases.
  always_comb begin
    op_div   = funct3[2];
    sgn_a_op = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sgn_b_op = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    neg_a    = sgn_a_op & rs1_val[XLEN-1];
    neg_b    = sgn_b_op & rs2_val[XLEN-1];
    mag_a    = cond_neg(rs1_val, neg_a);
    mag_b    = cond_neg(rs2_val, neg_b);
    div_zero = (rs2_val == '0);
    div_ovf  = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
               (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
    fast     = op_div & (div_zero | div_ovf);
    if (div_zero) fast_res = funct3[1] ? rs1_val : '1;
    else          fast_res = funct3[1] ? '0 : rs1_val;
  end

  // One shift-add or restore-subtract step, plus final sign fix-up.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, op_reg} : '0);
    mul_nxt  = {mul_sum, acc[XLEN-1:1]};
    div_rs   = acc[2*XLEN-1:XLEN-1];
    div_diff = div_rs - {1'b0, op_reg};
    div_nxt  = div_diff[XLEN] ? {div_rs[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    acc_nxt  = (state == DIV) ? div_nxt : mul_nxt;
    quo      = div_nxt[XLEN-1:0];
    rem      = div_nxt[2*XLEN-1:XLEN];
    if (state == DIV)
      final_res = f3_q[1] ? cond_neg(rem, neg_r) : cond_neg(quo, neg_p);
    else if (f3_q == 3'b000)
      final_res = mul_nxt[XLEN-1:0];
    else
      final_res = neg_hi(mul_nxt[2*XLEN-1:XLEN], mul_nxt[XLEN-1:0], neg_p);
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Sequencer next state, stall and done; reset masks the status outputs.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    md_done   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall     = 1'b1;
          state_nxt = fast ? DONE : (op_div ? DIV : MUL);
        end
      end
      MUL, DIV: begin
        stall = 1'b1;
        if (flush)             state_nxt = IDLE;
        else if (cnt == LAST)  state_nxt = DONE;
      end
      DONE: begin
        md_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      stall   = 1'b0;
      md_done = 1'b0;
    end
  end

  // Operand/accumulator datapath; no reset needed, always loaded at accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_reg <= op_div ? mag_b : mag_a;
      acc    <= {{XLEN{1'b0}}, (op_div ? mag_a : mag_b)};
      neg_p  <= neg_a ^ neg_b;
      neg_r  <= neg_a;
      f3_q   <= funct3;
    end else if (((state == MUL) || (state == DIV)) && !flush) begin
      acc <= acc_nxt;
    end
  end

  // Iteration counter and result register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      md_result <= '0;
    end else if (accept) begin
      cnt <= '0;
      if (fast) md_result <= fast_res;
    end else if (((state == MUL) || (state == DIV)) && !flush) begin
      cnt <= cnt + CW'(1);
      if (cnt == LAST) md_result <= final_res;
    end
  end

endmodule
